uart_bus_master: RTL

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master_if.sv | 22 ++
 rtl/uart_bus_master.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master_if.sv
// Bus interfaces for uart_bus_master: DatBus carries address, write data and
// byte enables; CtrBus carries the request/grant/response handshake.
interface DatBus;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;

   modport Master (output addr, wdata, be);
   modport Slave  (input  addr, wdata, be);
endinterface

interface CtrBus;
   logic        req;
   logic        we;
   logic        gnt;
   logic        rvalid;
   logic        err;
   logic [31:0] rdata;

   modport Master (output req, we, input  gnt, rvalid, err, rdata);
   modport Slave  (input  req, we, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/uart_bus_master.sv
// UART-driven 32-bit bus master: 'W' addr[4] data[4] -> 'K'/'E', 'R' addr[4] -> data[4]/'E'.
// Optional bus watchdog enabled by defining UBM_TIMEOUT_EN.
module uart_bus_master #(
   parameter int unsigned CLK_DIV = 16,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic  Clk,
   input  logic  Rst_n,
   input  logic  RX,
   output logic  TX,
   DatBus.Master CPUdat,
   CtrBus.Master CPUctr,
   output logic  Busy
);
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP} state_t;

   localparam logic [15:0] C_DIV_M1  = 16'(CLK_DIV - 1);
   localparam logic [15:0] C_HALF_M1 = 16'(CLK_DIV / 2 - 1);
   localparam logic [7:0]  C_CMD_W   = 8'h57;
   localparam logic [7:0]  C_CMD_R   = 8'h52;
   localparam logic [7:0]  C_ACK     = 8'h4B;
   localparam logic [7:0]  C_NAK     = 8'h45;

   if (CLK_DIV < 4 || CLK_DIV > 65535 || TIMEOUT == 0) begin : g_param_check
      $error("uart_bus_master: CLK_DIV or TIMEOUT out of range");
   end

   // Reset asserts asynchronously but releases only on a clock edge
   logic [1:0] r_rst_sync;
   logic       w_rst_n;
   // NOTE: sequential state always uses <= so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   assign w_rst_n = r_rst_sync[1];

   // ---------------- RX sampler ----------------
   rx_state_t   r_rx_state, w_rx_next;
   logic        r_rx_meta, r_rx_sync, r_rx_prev;
   logic [15:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_shift;
   logic        w_rx_tick, w_rx_done, w_rx_ferr;

   assign w_rx_tick = (r_rx_cnt == C_DIV_M1);

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      w_rx_next = r_rx_state;
      w_rx_done = 1'b0;
      w_rx_ferr = 1'b0;
      unique case (r_rx_state)
         RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
         RX_START: if (r_rx_cnt == C_HALF_M1) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
         RX_STOP:  if (w_rx_tick) begin
                      w_rx_next = RX_IDLE;
                      w_rx_done = r_rx_sync;
                      w_rx_ferr = !r_rx_sync;
                   end
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_rx_state <= RX_IDLE;
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_state <= w_rx_next;
         r_rx_meta  <= RX;
         r_rx_sync  <= r_rx_meta;
         r_rx_prev  <= r_rx_sync;
         if (r_rx_state == RX_IDLE || r_rx_state != w_rx_next || w_rx_tick) r_rx_cnt <= '0;
         else                                                               r_rx_cnt <= r_rx_cnt + 16'd1;
         if (r_rx_state == RX_IDLE) r_rx_bit <= '0;
         if (r_rx_state == RX_DATA && w_rx_tick) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end
      end

   // ---------------- Parser / bus / response FSM ----------------
   state_t      r_state, w_next;
   logic [31:0] r_addr, r_wdata, r_resp;
   logic        r_we;
   logic [1:0]  r_byte_cnt, r_resp_left;
   logic        r_tx;
   logic [8:0]  r_tx_sh;
   logic [3:0]  r_tx_bit;
   logic [15:0] r_tx_cnt;
   logic        w_to_expired, w_rsp_ok, w_resp_start, w_tx_last;
   logic [7:0]  w_tx_first;

`ifdef UBM_TIMEOUT_EN
   localparam logic [31:0] C_TO_M1 = 32'(TIMEOUT - 1);
   logic [31:0] r_to_cnt;
   always_ff @(posedge Clk or negedge w_rst_n)
      if (!w_rst_n)                                     r_to_cnt <= '0;
      else if (r_state == BUS_REQ || r_state == BUS_WAIT) r_to_cnt <= r_to_cnt + 32'd1;
      else                                              r_to_cnt <= '0;
   assign w_to_expired = (r_to_cnt == C_TO_M1);
`else
   assign w_to_expired = 1'b0;
`endif

   assign w_tx_last = (r_state == RESP) && (r_tx_cnt == C_DIV_M1) &&
                      (r_tx_bit == 4'd9) && (r_resp_left == 2'd0);

   always_comb begin
      w_next   = r_state;
      w_rsp_ok = (r_state == BUS_WAIT) && CPUctr.rvalid && !CPUctr.err;
      unique case (r_state)
         IDLE:     if (w_rx_done && (r_rx_shift == C_CMD_W || r_rx_shift == C_CMD_R)) w_next = ADDR;
         ADDR:     if (w_rx_ferr) w_next = IDLE;
                   else if (w_rx_done && r_byte_cnt == 2'd3) w_next = r_we ? DATA : BUS_REQ;
         DATA:     if (w_rx_ferr) w_next = IDLE;
                   else if (w_rx_done && r_byte_cnt == 2'd3) w_next = BUS_REQ;
         BUS_REQ:  if (w_to_expired) w_next = RESP;
                   else if (CPUctr.gnt) w_next = BUS_WAIT;
         BUS_WAIT: if (CPUctr.rvalid || w_to_expired) w_next = RESP;
         RESP:     if (w_tx_last) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   assign w_resp_start = (r_state != RESP) && (w_next == RESP);
   assign w_tx_first   = !w_rsp_ok ? C_NAK : (r_we ? C_ACK : CPUctr.rdata[31:24]);

   always_ff @(posedge Clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_we        <= 1'b0;
         r_byte_cnt  <= '0;
         r_resp      <= '0;
         r_resp_left <= '0;
         r_tx        <= 1'b1;
         r_tx_sh     <= '1;
         r_tx_bit    <= '0;
         r_tx_cnt    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next == ADDR) begin
            r_we       <= (r_rx_shift == C_CMD_W);
            r_byte_cnt <= '0;
         end
         if ((r_state == ADDR || r_state == DATA) && w_rx_done) r_byte_cnt <= r_byte_cnt + 2'd1;
         if (r_state == ADDR && w_rx_done) r_addr  <= {r_addr[23:0], r_rx_shift};
         if (r_state == DATA && w_rx_done) r_wdata <= {r_wdata[23:0], r_rx_shift};

         // The start bit of the first response byte is launched on the same edge as the FSM enters RESP
         if (w_resp_start) begin
            r_tx        <= 1'b0;
            r_tx_sh     <= {1'b1, w_tx_first};
            r_tx_bit    <= '0;
            r_tx_cnt    <= '0;
            r_resp      <= {CPUctr.rdata[23:0], 8'h00};
            r_resp_left <= (w_rsp_ok && !r_we) ? 2'd3 : 2'd0;
         end else if (r_state == RESP) begin
            if (r_tx_cnt == C_DIV_M1) begin
               r_tx_cnt <= '0;
               if (r_tx_bit == 4'd9) begin
                  if (r_resp_left != 2'd0) begin
                     r_tx        <= 1'b0;
                     r_tx_sh     <= {1'b1, r_resp[31:24]};
                     r_resp      <= {r_resp[23:0], 8'h00};
                     r_resp_left <= r_resp_left - 2'd1;
                     r_tx_bit    <= '0;
                  end
               end else begin
                  r_tx     <= r_tx_sh[0];
                  r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
                  r_tx_bit <= r_tx_bit + 4'd1;
               end
            end else begin
               r_tx_cnt <= r_tx_cnt + 16'd1;
            end
         end
      end

   assign TX           = r_tx;
   assign Busy         = (r_state != IDLE);
   assign CPUctr.req   = (r_state == BUS_REQ);
   assign CPUctr.we    = (r_state == BUS_REQ) && r_we;
   assign CPUdat.be    = (r_state == BUS_REQ) ? 4'hF : 4'h0;
   assign CPUdat.addr  = r_addr;
   assign CPUdat.wdata = r_wdata;

endmodule
